mips_dmem_responder: RTL and testbench



---
 rtl/mips_dmem_responder.sv | 134 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Wait-state data-memory responder for the MIPS load/store port.
// Define DMEM_MMIO_EN to add a cycle counter (0xFFFF0000) and scratch register (0xFFFF0004).
module mips_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          r_we;
    logic [31:0]   r_addr, r_wdata;
    logic [3:0]    r_be;
    logic          accept, rsp_done, go_resp;
    logic [AW-1:0] idx;
    logic          is_cyc, is_scr, err;
    logic [31:0]   rd_word;
    logic [31:0]   mem [DEPTH];

    assign accept   = req_valid & req_ready;
    assign rsp_done = rsp_valid & rsp_ready;
    assign go_resp  = (state == S_WAIT) && (cnt == '0);
    assign idx      = r_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (accept)     nxt = S_WAIT;
            S_WAIT:  if (cnt == '0)  nxt = S_RESP;
            S_RESP:  if (rsp_done)   nxt = S_IDLE;
            default:                 nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (accept) begin
            cnt     <= CW'(WAIT_CYCLES);
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] cyc_cnt, scr;

    assign is_cyc = (r_addr == 32'hFFFF_0000);
    assign is_scr = (r_addr == 32'hFFFF_0004);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            scr     <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (go_resp && is_scr && r_we) begin
                for (int b = 0; b < 4; b++)
                    if (r_be[b]) scr[8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[idx];
        if (is_cyc)      rd_word = cyc_cnt;
        else if (is_scr) rd_word = scr;
    end
`else
    assign is_cyc  = 1'b0;
    assign is_scr  = 1'b0;
    assign rd_word = mem[idx];
`endif

    // MMIO addresses skip the range check; the counter itself is read-only
    assign err = (r_addr[1:0] != 2'b00)
               | (({1'b0, r_addr} >= LIMIT) & ~is_cyc & ~is_scr)
               | (is_cyc & r_we);

    always_ff @(posedge clk) begin
        if (reset && go_resp && r_we && !err && !is_scr) begin
            for (int b = 0; b < 4; b++)
                if (r_be[b]) mem[idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (go_resp) begin
            rsp_err   <= err;
            rsp_rdata <= (r_we || err) ? 32'd0 : rd_word;
        end else if (rsp_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: directed table, corner sequences and a
// randomized run against a word-array model (instance 1 uses WAIT_CYCLES=0).
module tb_mips_dmem_responder;
    localparam int D0 = 1024;
    localparam int W0 = 2;
    localparam int D1 = 16;
    localparam int W1 = 0;
    localparam logic [31:0] BASE = 32'h100;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int errors = 0;
    int checks = 0;
    int cyc_tb = 0;
    vec_t tbl[$];
    logic [31:0] mdl [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_tb <= cyc_tb + 1;

    mips_dmem_responder #(.DEPTH(D0), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mips_dmem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int exp_lat(input int d);
        return (d == 0) ? W0 + 1 : W1 + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.be = be;
        v.hold = hold; v.erd = erd; v.eerr = eerr;
        tbl.push_back(v);
    endtask

    task automatic issue(input int d, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int acc);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("d%0d req_ready_idle", d), 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        @(posedge clk);
        #1;
        acc = cyc_tb;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
    endtask

    task automatic wait_rsp(input int d);
        int lat;
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            chk($sformatf("d%0d req_ready_busy", d), 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("d%0d latency", d), 32'(lat), 32'(exp_lat(d)));
    endtask

    task automatic drain(input int d, input int hold, input logic cd,
                         input logic [31:0] erd, input logic eerr,
                         output logic [31:0] rd);
        rd = rsp_rdata[d];
        if (cd) chk($sformatf("d%0d rdata", d), rsp_rdata[d], erd);
        chk($sformatf("d%0d err", d), 32'(rsp_err[d]), 32'(eerr));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("d%0d hold_valid", d), 32'(rsp_valid[d]), 32'd1);
            if (cd) chk($sformatf("d%0d hold_rdata", d), rsp_rdata[d], erd);
            chk($sformatf("d%0d hold_err", d), 32'(rsp_err[d]), 32'(eerr));
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        chk($sformatf("d%0d ready_after_hs", d), 32'(req_ready[d]), 32'd1);
        chk($sformatf("d%0d valid_after_hs", d), 32'(rsp_valid[d]), 32'd0);
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, input logic [31:0] erd, input logic eerr);
        int acc;
        logic [31:0] rd;
        issue(d, we, a, wd, be, acc);
        wait_rsp(d);
        drain(d, hold, 1'b1, erd, eerr, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2, w, r, hold;
        logic we, is_err;
        logic [3:0] be;
        logic [31:0] a, wd, erd, rd, rd2;
        longint la;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b0;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_req_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("d%0d rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("d%0d rst_rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("d%0d rst_err", d), 32'(rsp_err[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        add(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        add(1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0);
        add(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 1'b0);
        add(1'b1, 32'h20, 32'h00000000, 4'h5, 0, 32'h0, 1'b0);
        add(1'b0, 32'h20, 32'h0, 4'h0, 2, 32'hFF00FF00, 1'b0);
        add(1'b0, 32'h13, 32'h0, 4'hF, 1, 32'h0, 1'b1);
        add(1'b1, 32'h0, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
        add(1'b1, 32'(D0 * 4), 32'h99999999, 4'hF, 0, 32'h0, 1'b1);
        add(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h11223344, 1'b0);
        add(1'b1, 32'h22, 32'h77777777, 4'hF, 0, 32'h0, 1'b1);
        add(1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hFF00FF00, 1'b0);
        add(1'b1, 32'h30, 32'h55555555, 4'hF, 0, 32'h0, 1'b0);
        add(1'b1, 32'h30, 32'hAAAAAAAA, 4'h0, 0, 32'h0, 1'b0);
        add(1'b0, 32'h30, 32'h0, 4'hF, 3, 32'h55555555, 1'b0);
        add(1'b1, 32'(D0 * 4 - 4), 32'hC0FFEE00, 4'hF, 0, 32'h0, 1'b0);
        add(1'b0, 32'(D0 * 4 - 4), 32'h0, 4'h0, 0, 32'hC0FFEE00, 1'b0);
`ifndef DMEM_MMIO_EN
        add(1'b0, 32'hFFFF0000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        add(1'b1, 32'hFFFF0004, 32'h12, 4'hF, 0, 32'h0, 1'b1);
`endif
        foreach (tbl[i])
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                tbl[i].hold, tbl[i].erd, tbl[i].eerr);

        // zero-wait instance
        txn(1, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF, 0, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h3C, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b0);
        txn(1, 1'b1, 32'(D1 * 4), 32'h1, 4'hF, 0, 32'h0, 1'b1);
        txn(1, 1'b0, 32'h3E, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        txn(1, 1'b0, 32'h3C, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b0);

        // reset while a store waits: RAM must stay untouched
        txn(0, 1'b1, 32'h40, 32'h0, 4'hF, 0, 32'h0, 1'b0);
        issue(0, 1'b1, 32'h40, 32'h12345678, 4'hF, acc);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rstwait rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rstwait req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        // reset while a store response is pending: store already committed
        issue(0, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF, acc);
        wait_rsp(0);
        reset = 1'b0;
        #1;
        chk("rstresp rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rstresp req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_MMIO_EN
        issue(0, 1'b0, 32'hFFFF0000, 32'h0, 4'h0, acc);
        wait_rsp(0);
        drain(0, 0, 1'b0, 32'h0, 1'b0, rd);
        repeat (7) @(negedge clk);
        issue(0, 1'b0, 32'hFFFF0000, 32'h0, 4'h0, acc2);
        wait_rsp(0);
        drain(0, 1, 1'b0, 32'h0, 1'b0, rd2);
        chk("mmio cyc_delta", rd2 - rd, 32'(acc2 - acc));
        txn(0, 1'b1, 32'hFFFF0000, 32'h5, 4'hF, 0, 32'h0, 1'b1);
        txn(0, 1'b1, 32'hFFFF0004, 32'h000000A5, 4'h1, 0, 32'h0, 1'b0);
        txn(0, 1'b0, 32'hFFFF0004, 32'h0, 4'h0, 0, 32'h000000A5, 1'b0);
        txn(0, 1'b0, 32'hFFFF0006, 32'h0, 4'h0, 0, 32'h0, 1'b1);
`endif

        // randomized run against a word-array model
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            mdl[i] = wd;
            txn(0, 1'b1, BASE + 32'(4 * i), wd, 4'hF, 0, 32'h0, 1'b0);
        end
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            w  = $urandom_range(0, 15);
            we = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            hold = $urandom_range(0, 3);
            if (r == 0)      la = longint'(BASE) + 4 * w + $urandom_range(1, 3);
            else if (r == 1) la = longint'(D0) * 4 + 4 * $urandom_range(0, 1000);
            else             la = longint'(BASE) + 4 * w;
            a = 32'(la);
            is_err = (la % 4 != 0) || (la >= longint'(D0) * 4);
            erd = (is_err || we) ? 32'h0 : mdl[w];
            if (we && !is_err)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
            txn(0, we, a, wd, be, hold, erd, is_err);
        end
        for (int i = 0; i < 16; i++)
            txn(0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, 0, mdl[i], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
